// File: rtl/operator_sched_if.sv
// Request/response and operator-side bundle of operator_sched.
// master = scheduler side, slave = requesters, sink and operator IP.
interface operator_sched_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [32*NUM_REQ-1:0] req_c;
  logic [32*NUM_REQ-1:0] req_mode;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [IDW-1:0]        resp_id;
  logic [63:0]           resp_z;

  logic [31:0]           op_reg_addr;
  logic [31:0]           op_reg_wr_data;
  logic                  op_reg_wr;
  logic [31:0]           op_a;
  logic [31:0]           op_b;
  logic [31:0]           op_c;
  logic [63:0]           op_z;

  logic                  busy;

  modport master (
    input  req_valid, req_a, req_b,
    input  req_c, req_mode,
    output req_ready,
    output resp_valid, resp_id, resp_z,
    input  resp_ready,
    output op_reg_addr, op_reg_wr_data,
    output op_reg_wr,
    output op_a, op_b, op_c,
    input  op_z,
    output busy
  );

  modport slave (
    output req_valid, req_a, req_b,
    output req_c, req_mode,
    input  req_ready,
    input  resp_valid, resp_id, resp_z,
    output resp_ready,
    input  op_reg_addr, op_reg_wr_data,
    input  op_reg_wr,
    input  op_a, op_b, op_c,
    output op_z,
    input  busy
  );
endinterface

// File: rtl/operator_sched.sv
// Round-robin scheduler sharing one operator datapath between requesters.
// Ports: clk, rst (async active-low), bus (operator_sched_if.master).
module operator_sched #(
  parameter int          NUM_REQ    = 4,
  parameter int          OP_LATENCY = 3,
  parameter logic [31:0] CFG_ADDR   = 32'h0000_0010
) (
  input logic              clk,
  input logic              rst,
  operator_sched_if.master bus
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(OP_LATENCY + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(OP_LATENCY);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    CFG,
    EXEC,
    RESP
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    lm_q, lm_d;
  logic           lmv_q, lmv_d;
  logic [31:0]    a_q, a_d;
  logic [31:0]    b_q, b_d;
  logic [31:0]    c_q, c_d;
  logic [31:0]    mode_q, mode_d;
  logic [IDW-1:0] id_q, id_d;
  logic [31:0]    opa_q, opa_d;
  logic [31:0]    opb_q, opb_d;
  logic [31:0]    opc_q, opc_d;
  logic [63:0]    rz_q, rz_d;
  logic [IDW-1:0] rid_q, rid_d;

  logic           gnt_vld;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] gnt_nxt;
  logic [31:0]    sel_a;
  logic [31:0]    sel_b;
  logic [31:0]    sel_c;
  logic [31:0]    sel_m;

  // Walk downward so the lowest offset from rr_ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      logic [IDW-1:0] idx;
      idx = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (bus.req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  assign gnt_nxt = IDW'((int'(gnt_idx) + 1) % NUM_REQ);
  assign sel_a   = bus.req_a[32*gnt_idx +: 32];
  assign sel_b   = bus.req_b[32*gnt_idx +: 32];
  assign sel_c   = bus.req_c[32*gnt_idx +: 32];
  assign sel_m   = bus.req_mode[32*gnt_idx +: 32];

  always_comb begin
    state_d            = state_q;
    rr_ptr_d           = rr_ptr_q;
    cnt_d              = cnt_q;
    lm_d               = lm_q;
    lmv_d              = lmv_q;
    a_d                = a_q;
    b_d                = b_q;
    c_d                = c_q;
    mode_d             = mode_q;
    id_d               = id_q;
    opa_d              = opa_q;
    opb_d              = opb_q;
    opc_d              = opc_q;
    rz_d               = rz_q;
    rid_d              = rid_q;
    bus.req_ready      = '0;
    bus.resp_valid     = 1'b0;
    bus.op_reg_wr      = 1'b0;
    bus.op_reg_addr    = '0;
    bus.op_reg_wr_data = '0;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          bus.req_ready[gnt_idx] = 1'b1;
          a_d      = sel_a;
          b_d      = sel_b;
          c_d      = sel_c;
          mode_d   = sel_m;
          id_d     = gnt_idx;
          rr_ptr_d = gnt_nxt;
          if (!lmv_q || sel_m != lm_q) begin
            state_d = CFG;
          end else begin
            // Same mode as last time: skip the register write.
            state_d = EXEC;
            opa_d   = sel_a;
            opb_d   = sel_b;
            opc_d   = sel_c;
            cnt_d   = CNT_INIT;
          end
        end
      end
      CFG: begin
        bus.op_reg_wr      = 1'b1;
        bus.op_reg_addr    = CFG_ADDR;
        bus.op_reg_wr_data = mode_q;
        lm_d    = mode_q;
        lmv_d   = 1'b1;
        opa_d   = a_q;
        opb_d   = b_q;
        opc_d   = c_q;
        cnt_d   = CNT_INIT;
        state_d = EXEC;
      end
      EXEC: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          rz_d    = bus.op_z;
          rid_d   = id_q;
          state_d = RESP;
        end
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      lm_q     <= '0;
      lmv_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      mode_q   <= '0;
      id_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      opc_q    <= '0;
      rz_q     <= '0;
      rid_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      lm_q     <= lm_d;
      lmv_q    <= lmv_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      mode_q   <= mode_d;
      id_q     <= id_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      opc_q    <= opc_d;
      rz_q     <= rz_d;
      rid_q    <= rid_d;
    end
  end

  assign bus.op_a    = opa_q;
  assign bus.op_b    = opb_q;
  assign bus.op_c    = opc_q;
  assign bus.resp_z  = rz_q;
  assign bus.resp_id = rid_q;
  assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_operator_sched.sv
// Bench for operator_sched: table vectors, hand sequences, random traffic.
// Operator IP modelled as a pipeline producing z={a+b,c}.
module tb_operator_sched;

  localparam int          NR  = 4;
  localparam int          LAT = 3;
  localparam logic [31:0] CA  = 32'h0000_0010;

  logic clk;
  logic rst;

  operator_sched_if #(.NUM_REQ(NR)) bus ();

  operator_sched #(
    .NUM_REQ   (NR),
    .OP_LATENCY(LAT),
    .CFG_ADDR  (CA)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // z becomes visible at the LAT-th edge after operands change.
  logic [63:0] zp [LAT-1];
  always @(posedge clk) begin
    zp[0] <= {bus.op_a + bus.op_b, bus.op_c};
    for (int i = 1; i < LAT - 1; i++) zp[i] <= zp[i-1];
  end
  assign bus.op_z = zp[LAT-2];

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] ra [NR];
  logic [31:0] rb [NR];
  logic [31:0] rc [NR];
  logic [31:0] rm [NR];

  int          m_ptr;
  bit          m_lv;
  logic [31:0] m_last;

  typedef struct {
    int          r;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] m;
    bit          cfg;
    logic [63:0] z;
  } vec_t;

  vec_t tbl [5];

  function automatic logic [63:0] fz(
    input logic [31:0] a, b, c);
    logic [31:0] s;
    s = a + b;
    return {s, c};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      bus.req_a[32*i +: 32]    = ra[i];
      bus.req_b[32*i +: 32]    = rb[i];
      bus.req_c[32*i +: 32]    = rc[i];
      bus.req_mode[32*i +: 32] = rm[i];
    end
  endtask

  // One transaction: grant, optional CFG, latency, result, hold, drain.
  task automatic serve(input int g, input bit drop,
                       input bit cfg,
                       input logic [31:0] mode,
                       input logic [63:0] z,
                       input int hold);
    int          cyc;
    int          wr_n;
    logic [31:0] wr_d;
    logic [31:0] wr_a;
    bit          rdy_bad;
    bit          stable;
    logic [63:0] z0;
    logic [1:0]  id0;
    cyc = 0;
    wr_n = 0;
    wr_d = '0;
    wr_a = '0;
    rdy_bad = 1'b0;
    #1;
    chk("grant", 64'(bus.req_ready), 64'(1 << g));
    step();
    if (drop) bus.req_valid[g] = 1'b0;
    while (!bus.resp_valid && cyc < 20) begin
      if (bus.req_ready != '0) rdy_bad = 1'b1;
      if (bus.op_reg_wr) begin
        wr_n++;
        wr_d = bus.op_reg_wr_data;
        wr_a = bus.op_reg_addr;
      end
      step();
      cyc++;
    end
    chk("latency", 64'(cyc), 64'(LAT + (cfg ? 1 : 0)));
    chk("cfg_wr_cnt", 64'(wr_n), 64'(cfg ? 1 : 0));
    if (cfg) begin
      chk("cfg_data", 64'(wr_d), 64'(mode));
      chk("cfg_addr", 64'(wr_a), 64'(CA));
    end
    chk("resp_z", bus.resp_z, z);
    chk("resp_id", 64'(bus.resp_id), 64'(g));
    chk("rdy_busy", 64'(rdy_bad), 64'd0);
    z0 = bus.resp_z;
    id0 = bus.resp_id;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      step();
      if (!(bus.resp_valid && bus.resp_z == z0 &&
            bus.resp_id == id0 && bus.busy &&
            bus.req_ready == '0))
        stable = 1'b0;
    end
    if (hold > 0) chk("hold", 64'(stable), 64'd1);
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    chk("resp_drop", 64'(bus.resp_valid), 64'd0);
    chk("idle_busy", 64'(bus.busy), 64'd0);
  endtask

  function automatic int pick(input logic [NR-1:0] v,
                              input int ptr);
    for (int k = 0; k < NR; k++)
      if (v[(ptr + k) % NR]) return (ptr + k) % NR;
    return 0;
  endfunction

  // Reference scheduler: round-robin pick plus mode-change tracking.
  task automatic model_serve(input bit drop, input int hold,
                             output int g);
    bit cfg;
    g = pick(bus.req_valid, m_ptr);
    cfg = !m_lv || (rm[g] != m_last);
    serve(g, drop, cfg, rm[g], fz(ra[g], rb[g], rc[g]), hold);
    m_ptr = (g + 1) % NR;
    m_lv = 1'b1;
    m_last = rm[g];
  endtask

  initial begin
    int g;
    tbl[0] = '{0, 32'd3, 32'd4, 32'd10, 32'd5, 1'b1,
               64'h0000_0007_0000_000A};
    tbl[1] = '{0, 32'd1, 32'd1, 32'd2, 32'd5, 1'b0,
               64'h0000_0002_0000_0002};
    tbl[2] = '{1, 32'd6, 32'd6, 32'd1, 32'd7, 1'b1,
               64'h0000_000C_0000_0001};
    tbl[3] = '{2, 32'hFFFF_FFFF, 32'd2, 32'd9, 32'd9, 1'b1,
               64'h0000_0001_0000_0009};
    tbl[4] = '{1, 32'd8, 32'd0, 32'd8, 32'd7, 1'b1,
               64'h0000_0008_0000_0008};

    rst = 1'b0;
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_c      = '0;
    bus.req_mode   = '0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < NR; i++) begin
      ra[i] = '0; rb[i] = '0; rc[i] = '0; rm[i] = '0;
    end
    repeat (3) step();
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_rvalid", 64'(bus.resp_valid), 64'd0);
    chk("rst_z", bus.resp_z, 64'd0);
    chk("rst_opa", 64'(bus.op_a), 64'd0);
    chk("rst_wr", 64'(bus.op_reg_wr), 64'd0);
    rst = 1'b1;
    step();

    // Set last mode to 5, then reset in EXEC with mode 5 again.
    ra[0] = 32'd11; rb[0] = 32'd22; rc[0] = 32'd33; rm[0] = 32'd5;
    drive();
    bus.req_valid = 4'b0001;
    serve(0, 1'b1, 1'b1, 32'd5, fz(ra[0], rb[0], rc[0]), 0);
    ra[0] = 32'd100; rb[0] = 32'd200; rc[0] = 32'd300;
    drive();
    bus.req_valid = 4'b0001;
    step();
    bus.req_valid = '0;
    chk("exec_busy", 64'(bus.busy), 64'd1);
    chk("exec_opa", 64'(bus.op_a), 64'd100);
    step();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_opa", 64'(bus.op_a), 64'd0);
    chk("arst_opc", 64'(bus.op_c), 64'd0);
    chk("arst_rvalid", 64'(bus.resp_valid), 64'd0);
    step();
    step();
    rst = 1'b1;
    step();

    foreach (tbl[i]) begin
      bus.req_valid = '0;
      ra[tbl[i].r] = tbl[i].a;
      rb[tbl[i].r] = tbl[i].b;
      rc[tbl[i].r] = tbl[i].c;
      rm[tbl[i].r] = tbl[i].m;
      drive();
      bus.req_valid[tbl[i].r] = 1'b1;
      serve(tbl[i].r, 1'b1, tbl[i].cfg, tbl[i].m, tbl[i].z, 0);
    end

    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    m_ptr = 0;
    m_lv = 1'b0;
    m_last = '0;

    // All requesters held valid; one long response stall.
    for (int i = 0; i < NR; i++) begin
      ra[i] = $urandom; rb[i] = $urandom;
      rc[i] = $urandom; rm[i] = 32'd5;
    end
    drive();
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      model_serve(1'b0, (k == 2) ? 10 : 0, g);
      chk("rr_order", 64'(g), 64'(k % NR));
    end
    bus.req_valid = '0;

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NR; i++) begin
        ra[i] = $urandom; rb[i] = $urandom;
        rc[i] = $urandom; rm[i] = $urandom_range(1, 3);
      end
      drive();
      bus.req_valid = 4'($urandom_range(1, 15));
      model_serve(1'b1, $urandom_range(0, 2), g);
      bus.req_valid = '0;
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
